execute_64: RTL and testbench
=============================

# execute_64

Execute stage of the 64-bit SEQ Y86-64 processor. Sits directly downstream of the decode stage:
- consumes `icode`/`ifun` and `valC` from fetch, and `valA`/`valB` from decode;
- computes `valE` and the branch/move condition `cnd` for memory, writeback and PC-update;
- owns the architectural condition-code register (ZF, SF, OF) and a sticky halt flag.

## Interface
Parameters:
- none (data width fixed at 64).

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: current instruction is valid; state updates only when high.
- `icode` input 4: instruction code.
- `ifun` input 4: function code.
- `valA` input 64: operand A from decode.
- `valB` input 64: operand B from decode.
- `valC` input 64: constant from fetch.
- `valE` output 64: ALU result, combinational.
- `cnd` output 1: condition result for cmovXX/jXX, combinational.
- `cc` output 3: registered flags {ZF, SF, OF}.
- `halted` output 1: registered sticky halt flag.
- `inv_instr` output 1: combinational; high when `in_valid` is high and `icode` > 4'hB.

## Operation
valE selection by icode:
- 2 cmovXX: `valA` + 0.
- 3 irmovq: `valC` + 0.
- 4 rmmovq, 5 mrmovq: `valB` + `valC`.
- 6 OPq: `valB` op `valA`.
  - ifun 0: add.
  - ifun 1: sub (`valB` − `valA`).
  - ifun 2: and.
  - ifun 3: xor.
  - ifun > 3: `valE` = 0, no CC update.
- 8 call, A pushq: `valB` − 8.
- 9 ret, B popq: `valB` + 8.
- 0 halt, 1 nop, 7 jXX, invalid: `valE` = 0.

Arithmetic:
- 64-bit two's complement; carry-out discarded (wrap-around).

Flags computed from an OPq result `t`:
- ZF = (t == 0).
- SF = t[63].
- OF for add: `valA`[63] == `valB`[63] and t[63] != `valA`[63].
- OF for sub: `valA`[63] != `valB`[63] and t[63] != `valB`[63].
- OF for and/xor: 0.

cnd (icode 2 or 7 only; otherwise 0), evaluated on the **registered** `cc`, i.e. flags before the current instruction:
- ifun 0: 1.
- ifun 1 le: (SF^OF)|ZF.
- ifun 2 l: SF^OF.
- ifun 3 e: ZF.
- ifun 4 ne: !ZF.
- ifun 5 ge: !(SF^OF).
- ifun 6 g: !(SF^OF) & !ZF.
- ifun > 6: 0.

State updates (rising edge, only when `in_valid`=1 and `halted`=0):
- icode 6 with ifun ≤ 3: `cc` ← computed flags.
- icode 0: `halted` ← 1.
- All other icodes leave `cc` and `halted` unchanged.

Halted behaviour:
- Once `halted`=1, `cc` and `halted` are frozen until `rst`.
- `valE` and `cnd` remain combinationally valid after halt.

## Timing
- Reset values: `cc` = 3'b100 (ZF=1, SF=0, OF=0); `halted` = 0.
- Combinational outputs follow inputs and need no reset value.
- Reset is asynchronous: asserting `rst` mid-operation clears state immediately, regardless of `clk`.
- Latency:
  - `valE`, `cnd`, `inv_instr`: 0 cycles (combinational).
  - `cc` and `halted`: visible the cycle after the update edge.
- Back-to-back: an OPq followed next cycle by a jXX/cmovXX sees the OPq flags.
- OPq and cmov in the same cycle is impossible (single instruction per cycle).
- `in_valid`=0: no state change; combinational outputs are still driven from the inputs.
- Invalid icode: no state change; `inv_instr`=1.

## Test plan
- Reset, then no clock edges: `cc`=3'b100, `halted`=0. Then jXX ifun 3 (je): `cnd`=1.
- OPq add, `valA`=64'h7FFF_FFFF_FFFF_FFFF, `valB`=1: `valE`=64'h8000_0000_0000_0000; after edge `cc`={0,1,1}. Next cycle jXX ifun 2 (jl): `cnd`=0.
- OPq sub, `valA`=5, `valB`=5: `valE`=0, `cc`→{1,0,0}. Next cycle cmovXX ifun 4 (ne): `cnd`=0, `valE`=5 when `valA`=5.
- pushq `valB`=64'h100: `valE`=64'hF8. popq `valB`=64'hF8: `valE`=64'h100. mrmovq `valB`=64'h10, `valC`=64'h8: `valE`=64'h18. Verify `cc` unchanged throughout.
- halt with `in_valid`=1 → `halted`=1 next cycle. Subsequent OPq xor producing 0 leaves `cc` unchanged. Assert `rst` asynchronously between edges: `halted`=0 and `cc`=3'b100 immediately.
- icode 4'hC with `in_valid`=1: `inv_instr`=1, `valE`=0, no `cc` change. Same OPq presented with `in_valid`=0: no `cc` change.

Source files
------------

// File: rtl/execute_64.sv
// Execute stage of the SEQ Y86-64 processor: ALU result, branch/move condition,
// condition-code register and sticky halt flag.
module execute_64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  icode,
    input  logic [3:0]  ifun,
    input  logic [63:0] valA,
    input  logic [63:0] valB,
    input  logic [63:0] valC,
    output logic [63:0] valE,
    output logic        cnd,
    output logic [2:0]  cc,
    output logic        halted,
    output logic        inv_instr
);

    localparam int unsigned W = 64;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_CMOV   = 4'h2;
    localparam logic [3:0] I_IRMOV  = 4'h3;
    localparam logic [3:0] I_RMMOV  = 4'h4;
    localparam logic [3:0] I_MRMOV  = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSH   = 4'hA;
    localparam logic [3:0] I_POP    = 4'hB;

    localparam logic [W-1:0] STACK_STEP = W'(8);

    logic [2:0] new_cc;
    logic       cc_upd;
    logic       zf, sf, of;

    assign zf = cc[2];
    assign sf = cc[1];
    assign of = cc[0];

    // ALU and flag generation
    always_comb begin
        valE   = '0;
        new_cc = cc;
        cc_upd = 1'b0;
        case (icode)
            I_CMOV:           valE = valA;
            I_IRMOV:          valE = valC;
            I_RMMOV, I_MRMOV: valE = valB + valC;
            I_OPQ: begin
                cc_upd = 1'b1;
                case (ifun)
                    4'h0: begin
                        valE      = valB + valA;
                        new_cc[0] = (valA[W-1] == valB[W-1]) && (valE[W-1] != valA[W-1]);
                    end
                    4'h1: begin
                        valE      = valB - valA;
                        new_cc[0] = (valA[W-1] != valB[W-1]) && (valE[W-1] != valB[W-1]);
                    end
                    4'h2: begin
                        valE      = valB & valA;
                        new_cc[0] = 1'b0;
                    end
                    4'h3: begin
                        valE      = valB ^ valA;
                        new_cc[0] = 1'b0;
                    end
                    default: begin
                        valE   = '0;
                        cc_upd = 1'b0;
                    end
                endcase
                new_cc[2] = (valE == '0);
                new_cc[1] = valE[W-1];
            end
            I_CALL, I_PUSH:   valE = valB - STACK_STEP;
            I_RET, I_POP:     valE = valB + STACK_STEP;
            default:          valE = '0;
        endcase
    end

    // Condition evaluated against flags left by the previous instruction
    always_comb begin
        cnd = 1'b0;
        if (icode == I_CMOV || icode == I_JXX) begin
            case (ifun)
                4'h0:    cnd = 1'b1;
                4'h1:    cnd = (sf ^ of) | zf;
                4'h2:    cnd = sf ^ of;
                4'h3:    cnd = zf;
                4'h4:    cnd = ~zf;
                4'h5:    cnd = ~(sf ^ of);
                4'h6:    cnd = ~(sf ^ of) & ~zf;
                default: cnd = 1'b0;
            endcase
        end
    end

    assign inv_instr = in_valid && (icode > I_POP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc     <= 3'b100;
            halted <= 1'b0;
        end else if (in_valid && !halted) begin
            if (cc_upd)
                cc <= new_cc;
            if (icode == I_HALT)
                halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_execute_64.sv
// Directed, table-driven bench for execute_64 with hand-written halt and reset sequences.
module tb_execute_64;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA, valB, valC;
    logic [63:0] valE;
    logic        cnd;
    logic [2:0]  cc;
    logic        halted;
    logic        inv_instr;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    execute_64 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .valE      (valE),
        .cnd       (cnd),
        .cc        (cc),
        .halted    (halted),
        .inv_instr (inv_instr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [3:0]  ic;
        logic [3:0]  fn;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] e_vale;
        logic        e_cnd;
        logic        e_inv;
        logic [2:0]  e_cc;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] e_vale, input logic e_cnd, input logic e_inv,
                       input logic [2:0] e_cc);
        vec_t t;
        t.v = v; t.ic = ic; t.fn = fn; t.a = a; t.b = b; t.c = c;
        t.e_vale = e_vale; t.e_cnd = e_cnd; t.e_inv = e_inv; t.e_cc = e_cc;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            passes++;
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        in_valid = v; icode = ic; ifun = fn; valA = a; valB = b; valC = c;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 4'h1, 4'h0, '0, '0, '0);

        // icode ifun valA valB valC -> valE cnd inv cc_after
        add(1, 4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 64'h0, 1, 0, 3'b100);                           // je after reset
        add(1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 64'h8000_0000_0000_0000, 0, 0, 3'b011);
        add(1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 3'b011);                           // jl
        add(1, 4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 3'b011);                           // jle
        add(1, 4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 64'h0, 1, 0, 3'b011);                           // jg
        add(1, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 64'h0, 0, 0, 3'b100);                           // sub equal
        add(1, 4'h2, 4'h4, 64'h5, 64'h9, 64'h0, 64'h5, 0, 0, 3'b100);                           // cmovne
        add(1, 4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 0, 0, 3'b100);                        // pushq
        add(1, 4'hB, 4'h0, 64'h0, 64'hF8, 64'h0, 64'h100, 0, 0, 3'b100);                        // popq
        add(1, 4'h5, 4'h0, 64'h0, 64'h10, 64'h8, 64'h18, 0, 0, 3'b100);                         // mrmovq
        add(1, 4'h4, 4'h0, 64'h0, 64'h20, 64'h4, 64'h24, 0, 0, 3'b100);                         // rmmovq
        add(1, 4'h3, 4'h0, 64'h0, 64'h0, 64'h1234, 64'h1234, 0, 0, 3'b100);                     // irmovq
        add(1, 4'h8, 4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 0, 0, 3'b100);                        // call
        add(1, 4'h9, 4'h0, 64'h0, 64'hF8, 64'h0, 64'h100, 0, 0, 3'b100);                        // ret
        add(1, 4'hC, 4'h1, 64'h1, 64'h0, 64'h0, 64'h0, 0, 1, 3'b100);                           // invalid icode
        add(0, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'b100);         // not valid
        add(1, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 3'b010);         // 0-1
        add(1, 4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 64'h0, 1, 0, 3'b010);                           // jl taken
        add(1, 4'h6, 4'h4, 64'h3, 64'h3, 64'h0, 64'h0, 0, 0, 3'b010);                           // bad ifun
        add(1, 4'h6, 4'h2, 64'hF0, 64'h0F, 64'h0, 64'h0, 0, 0, 3'b100);                         // and
        add(1, 4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 3'b001);
        add(1, 4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 3'b001);                           // jge
        add(1, 4'h2, 4'h6, 64'h7, 64'h0, 64'h0, 64'h7, 0, 0, 3'b001);                           // cmovg
        add(1, 4'h6, 4'h3, 64'hFF, 64'h0F, 64'h0, 64'hF0, 0, 0, 3'b000);                        // xor
        add(1, 4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 3'b000);                           // ifun 7
        add(1, 4'h1, 4'h0, 64'h0, 64'h0, 64'h0, 64'h0, 0, 0, 3'b000);                           // nop
        add(1, 4'h7, 4'h0, 64'h0, 64'h0, 64'h0, 64'h0, 1, 0, 3'b000);                           // jmp

        // reset state, no clock edge seen yet
        #2;
        chk("reset_cc", 64'(cc), 64'(3'b100));
        chk("reset_halted", 64'(halted), 64'(1'b0));
        #1 rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].v, vecs[i].ic, vecs[i].fn, vecs[i].a, vecs[i].b, vecs[i].c);
            #1;
            chk($sformatf("v%0d_valE", i), valE, vecs[i].e_vale);
            chk($sformatf("v%0d_cnd", i), 64'(cnd), 64'(vecs[i].e_cnd));
            chk($sformatf("v%0d_inv", i), 64'(inv_instr), 64'(vecs[i].e_inv));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_cc", i), 64'(cc), 64'(vecs[i].e_cc));
            chk($sformatf("v%0d_halted", i), 64'(halted), 64'(1'b0));
        end

        // halt: sticky, freezes cc
        drive(1'b1, 4'h0, 4'h0, '0, '0, '0);
        #1 chk("halt_valE", valE, 64'h0);
        @(posedge clk); #1;
        chk("halt_set", 64'(halted), 64'(1'b1));
        chk("halt_cc", 64'(cc), 64'(3'b000));

        drive(1'b1, 4'h6, 4'h3, 64'h5, 64'h5, '0);
        #1 chk("halted_xor_valE", valE, 64'h0);
        @(posedge clk); #1;
        chk("halted_cc_frozen", 64'(cc), 64'(3'b000));
        chk("halted_stays", 64'(halted), 64'(1'b1));

        drive(1'b1, 4'h7, 4'h4, '0, '0, '0);
        #1 chk("halted_jne_cnd", 64'(cnd), 64'(1'b1));

        // async reset between edges
        #1 rst = 1'b1;
        #1;
        chk("async_rst_halted", 64'(halted), 64'(1'b0));
        chk("async_rst_cc", 64'(cc), 64'(3'b100));
        chk("async_rst_jne_cnd", 64'(cnd), 64'(1'b0));
        #1 rst = 1'b0;

        // state updates resume after reset
        drive(1'b1, 4'h6, 4'h1, 64'h1, 64'h0, '0);
        @(posedge clk); #1;
        chk("post_rst_cc", 64'(cc), 64'(3'b010));
        chk("post_rst_halted", 64'(halted), 64'(1'b0));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
